// File: rtl/genome_axi_write_master_if.sv
// AXI4 write-channel and AXI4-Stream bundle for genome_axi_write_master.
// The master modport is the write master's view; slave is the memory/stream side.
interface genome_axi_write_master_if #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512
);
   logic                            m_axi_awvalid;
   logic                            m_axi_awready;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [7:0]                      m_axi_awlen;
   logic                            m_axi_wvalid;
   logic                            m_axi_wready;
   logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                            m_axi_wlast;
   logic                            m_axi_bvalid;
   logic                            m_axi_bready;
   logic [1:0]                      m_axi_bresp;
   logic                            s_axis_tvalid;
   logic                            s_axis_tready;
   logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata;

   modport master (
      output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
      input  m_axi_awready,
      output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
      input  m_axi_wready,
      input  m_axi_bvalid, m_axi_bresp,
      output m_axi_bready,
      input  s_axis_tvalid, s_axis_tdata,
      output s_axis_tready
   );

   modport slave (
      input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
      output m_axi_awready,
      input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
      output m_axi_wready,
      output m_axi_bvalid, m_axi_bresp,
      input  m_axi_bready,
      output s_axis_tvalid, s_axis_tdata,
      input  s_axis_tready
   );
endinterface

// File: rtl/genome_axi_write_master.sv
// AXI4 write master: streams s_axis beats into a contiguous memory region using
// C_BURST_LEN-beat bursts, up to C_MAX_OUTSTANDING in flight, byte-accurate last beat.
module genome_axi_write_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
   parameter int unsigned C_BURST_LEN        = 64,
   parameter int unsigned C_MAX_OUTSTANDING  = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          ctrl_start,
   output logic                          ctrl_done,
   output logic                          ctrl_busy,
   output logic                          ctrl_error,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   genome_axi_write_master_if.master     bus
);
   localparam int unsigned DW_BYTES    = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned BYTE_SHIFT  = $clog2(DW_BYTES);
   localparam int unsigned BURST_SHIFT = $clog2(C_BURST_LEN);
   localparam int unsigned CNT_W       = C_XFER_SIZE_WIDTH + 1;
   localparam int unsigned LEN_W       = BURST_SHIFT + 1;
   localparam int unsigned OST_W       = $clog2(C_MAX_OUTSTANDING + 1);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_STEP =
      C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * DW_BYTES);
   localparam logic [DW_BYTES-1:0] STRB_ALL = '1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                        state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
   cnt_t                          bursts_q, aw_cnt_q, w_burst_q, b_cnt_q;
   logic [LEN_W-1:0]              last_len_q, beat_q;
   logic [BYTE_SHIFT-1:0]         rem_q;
   logic [OST_W-1:0]              ost_q, cred_q;
   logic                          done_q, error_q;

   logic             run, start_acc, size_zero;
   logic             aw_hs, w_hs, b_hs;
   logic             aw_final, w_final_burst, b_final, beat_last;
   logic [LEN_W-1:0] w_len, awlen_full;
   cnt_t             size_ext, beats, bursts;
   logic [LEN_W-1:0] last_len;

   always_comb begin
      run       = (state_q == StRun);
      size_zero = (ctrl_xfer_size_in_bytes == '0);
      start_acc = !run && ctrl_start;

      // Ceil divisions done once at start; the extra counter bit absorbs the rounding carry.
      size_ext = {1'b0, ctrl_xfer_size_in_bytes};
      beats    = (size_ext + cnt_t'(DW_BYTES - 1)) >> BYTE_SHIFT;
      bursts   = (beats + cnt_t'(C_BURST_LEN - 1)) >> BURST_SHIFT;
      last_len = LEN_W'((beats - cnt_t'(1)) & cnt_t'(C_BURST_LEN - 1)) + LEN_W'(1);

      aw_final      = (aw_cnt_q == bursts_q - cnt_t'(1));
      w_final_burst = (w_burst_q == bursts_q - cnt_t'(1));
      b_final       = (b_cnt_q == bursts_q - cnt_t'(1));
      w_len         = w_final_burst ? last_len_q : LEN_W'(C_BURST_LEN);
      beat_last     = (beat_q == w_len - LEN_W'(1));
      awlen_full    = aw_final ? (last_len_q - LEN_W'(1)) : LEN_W'(C_BURST_LEN - 1);

      bus.m_axi_awvalid = run && (aw_cnt_q < bursts_q) && (ost_q < OST_W'(C_MAX_OUTSTANDING));
      bus.m_axi_awaddr  = run ? awaddr_q : '0;
      bus.m_axi_awlen   = run ? 8'(awlen_full) : 8'd0;
      bus.m_axi_wvalid  = run && bus.s_axis_tvalid && (cred_q != '0);
      bus.s_axis_tready = run && bus.m_axi_wready && (cred_q != '0);
      bus.m_axi_wdata   = run ? bus.s_axis_tdata : '0;
      bus.m_axi_wlast   = run && beat_last;
      bus.m_axi_bready  = run;
      if (!run) begin
         bus.m_axi_wstrb = '0;
      end else if (w_final_burst && beat_last && (rem_q != '0)) begin
         bus.m_axi_wstrb = ~(STRB_ALL << rem_q);
      end else begin
         bus.m_axi_wstrb = STRB_ALL;
      end

      aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
      w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
      b_hs  = run && bus.m_axi_bvalid;

      ctrl_done  = done_q;
      ctrl_busy  = run;
      ctrl_error = error_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (ctrl_start && !size_zero) state_d = StRun;
         StRun:   if (b_hs && b_final) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= StIdle;
         awaddr_q   <= '0;
         bursts_q   <= '0;
         last_len_q <= '0;
         rem_q      <= '0;
         aw_cnt_q   <= '0;
         w_burst_q  <= '0;
         beat_q     <= '0;
         b_cnt_q    <= '0;
         ost_q      <= '0;
         cred_q     <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (start_acc && size_zero) || (b_hs && b_final);
         if (start_acc) begin
            error_q    <= 1'b0;
            awaddr_q   <= ctrl_addr_offset;
            bursts_q   <= bursts;
            last_len_q <= last_len;
            rem_q      <= ctrl_xfer_size_in_bytes[BYTE_SHIFT-1:0];
            aw_cnt_q   <= '0;
            w_burst_q  <= '0;
            beat_q     <= '0;
            b_cnt_q    <= '0;
            ost_q      <= '0;
            cred_q     <= '0;
         end else if (run) begin
            if (aw_hs) begin
               aw_cnt_q <= aw_cnt_q + cnt_t'(1);
               awaddr_q <= awaddr_q + BURST_STEP;
            end
            if (w_hs) begin
               if (beat_last) begin
                  beat_q    <= '0;
                  w_burst_q <= w_burst_q + cnt_t'(1);
               end else begin
                  beat_q <= beat_q + LEN_W'(1);
               end
            end
            if (b_hs) begin
               b_cnt_q <= b_cnt_q + cnt_t'(1);
               if (bus.m_axi_bresp != 2'b00) error_q <= 1'b1;
            end
            if (aw_hs && !b_hs) ost_q <= ost_q + OST_W'(1);
            else if (!aw_hs && b_hs) ost_q <= ost_q - OST_W'(1);
            // Credit: bursts whose address was accepted but whose data is not yet complete.
            if (aw_hs && !(w_hs && beat_last)) cred_q <= cred_q + OST_W'(1);
            else if (!aw_hs && w_hs && beat_last) cred_q <= cred_q - OST_W'(1);
         end
      end
   end
endmodule
